ai_density_engine: RTL and testbench

//  Parametrised probability-density shot selector for the BattleChip AI.
//  - Memory-mapped slave on the HPS bus, with a wait_request stall.
//  - Holds the fired, hit and live-ship state. On start it counts every legal

---
 rtl/ai_pkg.sv | 39 +++
 rtl/ai_placement_check.sv | 29 ++
 rtl/ai_density_engine.sv | 236 +++++++++++++++++++++++
 tb/tb_ai_density_engine.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ai_pkg.sv
// Shared types and register-map helpers for the density shot selector.
package ai_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR  = 3'd0,
        ST_IDLE   = 3'd1,
        ST_SCAN   = 3'd2,
        ST_ARGMAX = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Slot i length lives at [i*4+:4]: slots 0..4 = 5,4,3,3,2.
    localparam logic [19:0] DEF_SHIP_LEN = 20'h23345;

    // Result word layout.
    localparam int NO_MOVE_BIT  = 31;
    localparam int FALLBACK_BIT = 30;
    localparam int MAXD_LSB     = 16;

    localparam int REG_CTRL  = 0;
    localparam int REG_FIRED = 1;

    function automatic int fw_of(input int n);
        return (n + 31) / 32;
    endfunction

    function automatic int reg_hits(input int fw);
        return fw + 1;
    endfunction

    function automatic int reg_ships(input int fw);
        return 2 * fw + 1;
    endfunction

    function automatic int reg_stat(input int fw);
        return 2 * fw + 2;
    endfunction

endpackage

// File: rtl/ai_placement_check.sv
// Legality of one ship placement given the window of cells it would cover.
// Board fit is decided by the caller; this only looks at misses and hits.
module ai_placement_check #(
    parameter int WIN = 5
) (
    input  logic [WIN-1:0] fired,
    input  logic [WIN-1:0] hits,
    input  logic [3:0]     len,
    input  logic           hitmode,
    output logic           legal
);

    logic miss;
    logic any_hit;

    // Reject on any covered miss; in hit mode demand at least one covered hit.
    always_comb begin
        miss    = 1'b0;
        any_hit = 1'b0;
        for (int k = 0; k < WIN; k++) begin
            if (k < int'(len)) begin
                miss    = miss | (fired[k] & ~hits[k]);
                any_hit = any_hit | hits[k];
            end
        end
        legal = !miss && (!hitmode || any_hit);
    end

endmodule

// File: rtl/ai_density_engine.sv
// Probability-density shot selector: bus slave, placement scan, argmax.
module ai_density_engine
    import ai_pkg::*;
#(
    parameter int                     BOARD_W   = 10,
    parameter int                     BOARD_H   = 10,
    parameter int                     NUM_SHIPS = 5,
    parameter logic [NUM_SHIPS*4-1:0] SHIP_LEN  = DEF_SHIP_LEN,
    parameter int                     DENS_W    = 6,
    parameter int                     ADDR_W    = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              write_en,
    input  logic              read_en,
    input  logic [31:0]       data_in,
    output logic              wait_request,
    output logic [31:0]       data_out
);

    localparam int N     = BOARD_W * BOARD_H;
    localparam int FW    = fw_of(N);
    localparam int PADW  = FW * 32;
    localparam int PW    = $clog2(N);
    localparam int XW    = $clog2(BOARD_W);
    localparam int YW    = $clog2(BOARD_H);
    localparam int INC_W = $clog2(2 * NUM_SHIPS + 1);
    localparam int DMAX  = (1 << DENS_W) - 1;

    state_t                         state;
    logic [N-1:0]                   fired, hits;
    logic [NUM_SHIPS-1:0]           ships;
    logic [31:0]                    result;
    logic [PW-1:0]                  pos, best_idx;
    logic [XW-1:0]                  px;
    logic [YW-1:0]                  py;
    logic                           parity_en, hitmode, found;
    logic [DENS_W-1:0]              best;
    logic [N-1:0][DENS_W-1:0]       dens;
    logic [N-1:0][INC_W-1:0]        inc;
    logic [NUM_SHIPS-1:0][1:0]      place_ok;
    logic [31:0]                    rdata, res_next;
    logic                           bus_ok, start, last, elig, busy;

    function automatic logic bit_at(input logic [N-1:0] v, input int i);
        logic [N-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic logic [31:0] rd_word(input logic [N-1:0] v, input int w);
        logic [PADW-1:0] p;
        p = PADW'(v);
        return p[w*32 +: 32];
    endfunction

    function automatic logic [N-1:0] wr_word(input logic [N-1:0] v, input int w,
                                             input logic [31:0] d);
        logic [PADW-1:0] p;
        p = PADW'(v);
        p[w*32 +: 32] = d;
        return p[N-1:0];
    endfunction

    // Bus is only open while not stalled (IDLE, and CLEAR after a finished run).
    assign bus_ok = !wait_request;
    assign start  = bus_ok && write_en && (addr == ADDR_W'(REG_CTRL));
    assign last   = (pos == PW'(N - 1));
    assign busy   = (state == ST_SCAN) || (state == ST_ARGMAX) || (state == ST_DONE);

    // Two placement checks per ship slot, anchored at the current scan cell.
    for (genvar i = 0; i < NUM_SHIPS; i++) begin : g_ship
        localparam int L  = int'(SHIP_LEN[i*4 +: 4]);
        localparam int WN = (L > 0) ? L : 1;
        logic [WN-1:0] hf, hh, vf, vh;
        logic          legal_h, legal_v, fit_h, fit_v;

        // Gather the horizontal and vertical windows starting at pos.
        always_comb begin
            for (int k = 0; k < WN; k++) begin
                hf[k] = bit_at(fired, int'(pos) + k);
                hh[k] = bit_at(hits,  int'(pos) + k);
                vf[k] = bit_at(fired, int'(pos) + k * BOARD_W);
                vh[k] = bit_at(hits,  int'(pos) + k * BOARD_W);
            end
        end

        assign fit_h = (int'(px) + L <= BOARD_W);
        assign fit_v = (int'(py) + L <= BOARD_H);

        ai_placement_check #(.WIN(WN)) u_h (
            .fired(hf), .hits(hh), .len(4'(L)), .hitmode(hitmode), .legal(legal_h));
        ai_placement_check #(.WIN(WN)) u_v (
            .fired(vf), .hits(vh), .len(4'(L)), .hitmode(hitmode), .legal(legal_v));

        assign place_ok[i] = {ships[i] & fit_v & legal_v, ships[i] & fit_h & legal_h};
    end

    // Per-cell increment: number of legal placements at pos covering the cell.
    always_comb begin
        int acc, d, l;
        for (int c = 0; c < N; c++) begin
            acc = 0;
            d   = c - int'(pos);
            for (int i = 0; i < NUM_SHIPS; i++) begin
                l = int'(SHIP_LEN[i*4 +: 4]);
                if (d >= 0) begin
                    if (place_ok[i][0] && d < l) acc++;
                    if (place_ok[i][1] && (d % BOARD_W) == 0 && (d / BOARD_W) < l) acc++;
                end
            end
            inc[c] = INC_W'(acc);
        end
    end

    // Eligibility of the current argmax cell; parity only gates hunt mode.
    assign elig = !fired[pos] && (!(parity_en && !hitmode) || (px[0] == py[0]));

    // Result word from the final argmax state.
    always_comb begin
        res_next = '0;
        if (!found) begin
            res_next[NO_MOVE_BIT] = 1'b1;
            res_next[15:0]        = 16'hFFFF;
        end else begin
            res_next[FALLBACK_BIT]          = (best == '0);
            res_next[MAXD_LSB +: 8]         = 8'(best);
            res_next[15:0]                  = 16'(best_idx);
        end
    end

    // Read mux; evaluated on pre-write state so a same-cycle write is not seen.
    always_comb begin
        rdata = '0;
        if (addr == ADDR_W'(REG_CTRL)) rdata = result;
        for (int w = 0; w < FW; w++) begin
            if (addr == ADDR_W'(REG_FIRED + w))     rdata = rd_word(fired, w);
            if (addr == ADDR_W'(reg_hits(FW) + w))  rdata = rd_word(hits, w);
        end
        if (addr == ADDR_W'(reg_ships(FW))) rdata[NUM_SHIPS-1:0] = ships;
        if (addr == ADDR_W'(reg_stat(FW)))  rdata[3:0] = {state, busy};
    end

    // Bus registers, scan/argmax sequencing and result publication.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_CLEAR;
            wait_request <= 1'b1;
            data_out     <= '0;
            result       <= '0;
            fired        <= '0;
            hits         <= '0;
            ships        <= '0;
            dens         <= '0;
            pos          <= '0;
            px           <= '0;
            py           <= '0;
            parity_en    <= 1'b0;
            hitmode      <= 1'b0;
            found        <= 1'b0;
            best         <= '0;
            best_idx     <= '0;
        end else begin
            if (bus_ok && read_en) data_out <= rdata;
            if (bus_ok && write_en) begin
                for (int w = 0; w < FW; w++) begin
                    if (addr == ADDR_W'(REG_FIRED + w))    fired <= wr_word(fired, w, data_in);
                    if (addr == ADDR_W'(reg_hits(FW) + w)) hits  <= wr_word(hits, w, data_in);
                end
                if (addr == ADDR_W'(reg_ships(FW))) ships <= data_in[NUM_SHIPS-1:0];
            end

            case (state)
                ST_CLEAR, ST_IDLE: begin
                    if (state == ST_CLEAR) begin
                        dens <= '0;
                        pos  <= '0;
                        px   <= '0;
                        py   <= '0;
                    end
                    wait_request <= start;
                    state        <= start ? ST_SCAN : ST_IDLE;
                    if (start) begin
                        parity_en <= data_in[1];
                        hitmode   <= |hits;
                    end
                end
                ST_SCAN: begin
                    for (int c = 0; c < N; c++) begin
                        if (int'(dens[c]) + int'(inc[c]) > DMAX) dens[c] <= DENS_W'(DMAX);
                        else                                     dens[c] <= dens[c] + DENS_W'(inc[c]);
                    end
                    if (last) begin
                        state <= ST_ARGMAX;
                        found <= 1'b0;
                        best  <= '0;
                    end
                end
                ST_ARGMAX: begin
                    if (elig && (!found || dens[pos] > best)) begin
                        found    <= 1'b1;
                        best     <= dens[pos];
                        best_idx <= pos;
                    end
                    if (last) state <= ST_DONE;
                end
                ST_DONE: begin
                    result       <= res_next;
                    data_out     <= res_next;
                    wait_request <= 1'b0;
                    state        <= ST_CLEAR;
                end
                default: state <= ST_CLEAR;
            endcase

            // Raster walk of pos/x/y shared by SCAN and ARGMAX.
            if (state == ST_SCAN || state == ST_ARGMAX) begin
                if (last) begin
                    pos <= '0;
                    px  <= '0;
                    py  <= '0;
                end else begin
                    pos <= pos + 1'b1;
                    if (px == XW'(BOARD_W - 1)) begin
                        px <= '0;
                        py <= py + 1'b1;
                    end else begin
                        px <= px + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ai_density_engine.sv
// Self-checking bench for ai_density_engine at the default 10x10 configuration.
module tb_ai_density_engine;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [4:0]  addr = '0;
    logic        write_en = 1'b0;
    logic        read_en = 1'b0;
    logic [31:0] data_in = '0;
    logic        wait_request;
    logic [31:0] data_out;

    int n_cmp = 0;
    int n_bad = 0;
    int lens[5] = '{5, 4, 3, 3, 2};

    typedef struct {
        logic [99:0] f;
        logic [99:0] h;
        logic [4:0]  sh;
        bit          par;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    ai_density_engine dut (
        .clock(clock), .reset_n(reset_n), .addr(addr), .write_en(write_en),
        .read_en(read_en), .data_in(data_in), .wait_request(wait_request),
        .data_out(data_out));

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_wait();
        int n = 0;
        while (wait_request && n < 1000) begin
            n++;
            @(negedge clock);
        end
        if (n >= 1000) chk("bus_wait_timeout", 32'(n), 32'd0);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus_wait();
        addr = a; data_in = d; write_en = 1'b1;
        @(negedge clock);
        write_en = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        bus_wait();
        addr = a; read_en = 1'b1;
        @(negedge clock);
        read_en = 1'b0;
        d = data_out;
    endtask

    task automatic load(input logic [99:0] f, input logic [99:0] h, input logic [4:0] sh);
        logic [127:0] fp, hp;
        fp = 128'(f);
        hp = 128'(h);
        for (int w = 0; w < 4; w++) wr(5'(1 + w), fp[w*32 +: 32]);
        for (int w = 0; w < 4; w++) wr(5'(5 + w), hp[w*32 +: 32]);
        wr(5'd9, 32'(sh));
    endtask

    // Start, count stalled cycles (bounded), return data_out at completion.
    task automatic run(input bit par, output logic [31:0] res, output int cyc);
        wr(5'd0, {30'd0, par, 1'b0});
        cyc = 0;
        while (wait_request && cyc < 1000) begin
            cyc++;
            @(negedge clock);
        end
        res = data_out;
    endtask

    // Reference: enumerate every placement on the board, then pick the best cell.
    function automatic logic [31:0] model(input logic [99:0] f, input logic [99:0] h,
                                          input logic [4:0] sh, input bit par);
        int  dens[100];
        bit  hm, ok, anyhit, el;
        int  l, cx, cy, c, best, bidx;
        hm = (h != '0);
        for (int i = 0; i < 100; i++) dens[i] = 0;
        for (int s = 0; s < 5; s++) begin
            if (!sh[s]) continue;
            l = lens[s];
            for (int o = 0; o < 2; o++)
                for (int y = 0; y < 10; y++)
                    for (int x = 0; x < 10; x++) begin
                        if ((o == 0) ? (x + l > 10) : (y + l > 10)) continue;
                        ok = 1; anyhit = 0;
                        for (int k = 0; k < l; k++) begin
                            cx = (o == 0) ? x + k : x;
                            cy = (o == 0) ? y : y + k;
                            c  = cy * 10 + cx;
                            if (f[c] && !h[c]) ok = 0;
                            if (h[c]) anyhit = 1;
                        end
                        if (hm && !anyhit) ok = 0;
                        if (ok)
                            for (int k = 0; k < l; k++) begin
                                cx = (o == 0) ? x + k : x;
                                cy = (o == 0) ? y : y + k;
                                dens[cy * 10 + cx]++;
                            end
                    end
        end
        best = -1; bidx = 0;
        for (int i = 0; i < 100; i++) begin
            if (dens[i] > 63) dens[i] = 63;
            el = !f[i] && (!(par && !hm) || (((i % 10) + (i / 10)) % 2 == 0));
            if (el && dens[i] > best) begin
                best = dens[i];
                bidx = i;
            end
        end
        if (best < 0) return 32'h8000_FFFF;
        return {1'b0, (best == 0), 6'd0, 8'(best), 16'(bidx)};
    endfunction

    task automatic add(input logic [99:0] f, input logic [99:0] h, input logic [4:0] sh,
                       input bit par, input logic [31:0] exp, input string name);
        vec_t v;
        v.f = f; v.h = h; v.sh = sh; v.par = par; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] r, res;
        logic [99:0] f, h, one;
        int          cyc;
        logic [4:0]  sh;
        bit          par;

        // Reset and post-reset register state
        repeat (2) @(negedge clock);
        chk("rst_wait_request", 32'(wait_request), 32'd1);
        chk("rst_data_out", data_out, 32'd0);
        reset_n = 1'b1;
        #1 chk("rst_release_wait_high", 32'(wait_request), 32'd1);
        @(negedge clock);
        chk("rst_wait_low_after_1", 32'(wait_request), 32'd0);
        for (int a = 0; a < 10; a++) begin
            rd(5'(a), r);
            chk($sformatf("rst_reg%0d", a), r, 32'd0);
        end
        rd(5'd10, r);
        chk("rst_status_idle", r, 32'h0000_0002);   // {state=IDLE(1), busy=0}

        // Directed boards; 98 is odd parity ((8+9)=17), 99 is even ((9+9)=18)
        f = '0; h = '0; one = 100'd1;
        add(f, h, 5'h1F, 1'b0, 32'h0022_002C, "empty_all_ships");
        add(one, one, 5'h1F, 1'b0, 32'h0005_0001, "hitmode_corner");
        f = '1; f[98] = 1'b0;
        add(f, '0, 5'h1F, 1'b1, 32'h8000_FFFF, "parity_no_move");
        add(f, '0, 5'h1F, 1'b0, 32'h4000_0062, "noparity_fallback98");
        f = '1; f[99] = 1'b0;
        add(f, '0, 5'h1F, 1'b1, 32'h4000_0063, "parity_fallback99");
        add('0, '0, 5'h00, 1'b0, 32'h4000_0000, "no_ships");
        add(one, '0, 5'h00, 1'b1, 32'h4000_0002, "no_ships_parity");
        foreach (vecs[i]) begin
            load(vecs[i].f, vecs[i].h, vecs[i].sh);
            run(vecs[i].par, res, cyc);
            chk({vecs[i].name, "_latency"}, 32'(cyc), 32'd201);
            chk({vecs[i].name, "_data_out"}, res, vecs[i].exp);
            rd(5'd0, r);
            chk({vecs[i].name, "_reg0"}, r, vecs[i].exp);
        end

        // Randomised boards against the reference model
        for (int t = 0; t < 10; t++) begin
            f = '0; h = '0;
            for (int c = 0; c < 100; c++) begin
                f[c] = ($urandom_range(0, 99) < 30);
                h[c] = f[c] && ($urandom_range(0, 99) < 25) && (t % 3 != 0);
            end
            sh  = 5'($urandom);
            par = 1'($urandom);
            load(f, h, sh);
            run(par, res, cyc);
            chk($sformatf("rand%0d", t), res, model(f, h, sh, par));
        end

        // Simultaneous write and read: read returns the old value
        wr(5'd1, 32'h0000_1111);
        addr = 5'd1; data_in = 32'h0000_2222; write_en = 1'b1; read_en = 1'b1;
        @(negedge clock);
        write_en = 1'b0; read_en = 1'b0;
        chk("rw_same_cycle_old", data_out, 32'h0000_1111);
        rd(5'd1, r);
        chk("rw_same_cycle_new", r, 32'h0000_2222);

        // Write to fired[95:64] while busy is dropped
        f = '0; f[64 +: 32] = 32'hA5A5_0000;
        load(f, '0, 5'h1F);
        wr(5'd0, 32'd0);
        addr = 5'd3; data_in = 32'h1234_5678; write_en = 1'b1;
        repeat (5) @(negedge clock);
        write_en = 1'b0;
        bus_wait();
        chk("busy_run_result", data_out, model(f, '0, 5'h1F, 1'b0));
        rd(5'd3, r);
        chk("busy_write_ignored", r, 32'hA5A5_0000);

        // Reset in the middle of SCAN
        wr(5'd0, 32'd0);
        repeat (50) @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("midrst_data_out", data_out, 32'd0);
        chk("midrst_wait_high", 32'(wait_request), 32'd1);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("midrst_idle", 32'(wait_request), 32'd0);
        rd(5'd3, r);
        chk("midrst_fired_cleared", r, 32'd0);
        rd(5'd9, r);
        chk("midrst_ships_cleared", r, 32'd0);
        rd(5'd0, r);
        chk("midrst_result_cleared", r, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
